round_robin_arbiter: RTL and testbench

// - N-way round-robin arbiter with a registered one-hot grant; one grant per clock.
// - Re-arbitrates every cycle; the most recent winner drops to lowest priority.
// - Shares a single resource among N requesters; sits between requesters and that resource.
// - No grant hold/lock; a requester wanting service must keep its req bit asserted.

---
 rtl/round_robin_arbiter_pkg.sv | 19 +
 rtl/round_robin_arbiter_if.sv | 23 ++
 rtl/round_robin_arbiter_fixed_prio_arb.sv | 17 +
 rtl/round_robin_arbiter.sv | 69 ++++++
 tb/tb_round_robin_arbiter.sv | 96 +++++++++
 5 files changed

// File: rtl/round_robin_arbiter_pkg.sv
// Shared constants and helpers for the round-robin arbiter slice.
// The one-hot index helper works on a fixed-width vector; callers zero-extend.
package round_robin_arbiter_pkg;

    localparam int unsigned RRA_MAX_N = 32;

    // Position of the set bit in a one-hot vector; zero vector maps to index 0.
    function automatic int unsigned rraOneHotIndex(input logic [RRA_MAX_N-1:0] oneHot);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < int'(RRA_MAX_N); i++) begin
            if (oneHot[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/round_robin_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface round_robin_arbiter_if #(
    parameter int N = 4
);

    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic         grant_valid;

    modport master (
        output req,
        input  grant,
        input  grant_valid
    );

    modport slave (
        input  req,
        output grant,
        output grant_valid
    );

endinterface

// File: rtl/round_robin_arbiter_fixed_prio_arb.sv
// Combinational fixed-priority picker: the lowest-index set bit of i_req wins.
// Two's-complement trick isolates the lowest set bit; an all-zero input yields zero.
module rr_fixed_prio_arb #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_grant
);

    logic [N-1:0] w_reqMinusOne;

    always_comb begin
        w_reqMinusOne = i_req - N'(1);
        o_grant       = i_req & ~w_reqMinusOne;
    end

endmodule

// File: rtl/round_robin_arbiter.sv
// N-way round-robin arbiter with a registered one-hot grant, re-arbitrated every cycle.
// The last winner drops to lowest priority; idle cycles leave the pointer untouched.
module round_robin_arbiter
    import round_robin_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rstn,
    round_robin_arbiter_if.slave bus
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(N - 1);

    logic [IDX_W-1:0] r_last;
    logic [N-1:0]     r_grant;
    logic             r_grantValid;

    logic [N-1:0]     w_mask;
    logic [N-1:0]     w_maskedReq;
    logic [N-1:0]     w_maskedGrant;
    logic [N-1:0]     w_rawGrant;
    logic [N-1:0]     w_nextGrant;
    logic [IDX_W-1:0] w_nextIdx;

    // Only requesters above the last winner are eligible in the masked pass.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (i > int'(r_last));
        end
        w_maskedReq = bus.req & w_mask;
    end

    rr_fixed_prio_arb #(.N(N)) u_maskedPick (
        .i_req   (w_maskedReq),
        .o_grant (w_maskedGrant)
    );

    rr_fixed_prio_arb #(.N(N)) u_rawPick (
        .i_req   (bus.req),
        .o_grant (w_rawGrant)
    );

    // Fall back to the unmasked pick when nobody above the pointer is asking (wrap-around).
    always_comb begin
        w_nextGrant = (|w_maskedGrant) ? w_maskedGrant : w_rawGrant;
        w_nextIdx   = IDX_W'(rraOneHotIndex(RRA_MAX_N'(w_nextGrant)));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_grant      <= '0;
            r_grantValid <= 1'b0;
            r_last       <= LAST_RESET;
        end else begin
            r_grant      <= w_nextGrant;
            r_grantValid <= |w_nextGrant;
            if (|w_nextGrant) begin
                r_last <= w_nextIdx;
            end
        end
    end

    assign bus.grant       = r_grant;
    assign bus.grant_valid = r_grantValid;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed self-checking bench for round_robin_arbiter with N=4.
// Each step drives req/rstn just after a posedge and checks the registered grant one edge later.
module tb_round_robin_arbiter;

    logic clk;
    logic rstn;
    int   compareCount;
    int   mismatchCount;

    round_robin_arbiter_if #(.N(4)) bus ();

    round_robin_arbiter #(.N(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, then check grant and grant_valid just after the next posedge.
    task automatic applyStimulus(input string tag, input logic rstnVal, input logic [3:0] reqVal,
                                 input logic [3:0] expGrant);
        rstn    = rstnVal;
        bus.req = reqVal;
        @(posedge clk);
        #1;
        checkOutput({tag, ".grant"}, 32'(bus.grant), 32'(expGrant));
        checkOutput({tag, ".valid"}, 32'(bus.grant_valid), 32'(|expGrant));
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        rstn    = 1'b0;
        bus.req = 4'b0000;

        @(posedge clk);
        #1;
        checkOutput("reset.grant", 32'(bus.grant), 32'd0);
        checkOutput("reset.valid", 32'(bus.grant_valid), 32'd0);
        #3;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle.grant", 32'(bus.grant), 32'd0);

        applyStimulus("first",    1'b1, 4'b0010, 4'b0010);
        applyStimulus("wrap",     1'b1, 4'b0001, 4'b0001);

        applyStimulus("cont0",    1'b1, 4'b1100, 4'b0100);
        applyStimulus("cont1",    1'b1, 4'b1100, 4'b1000);
        applyStimulus("cont2",    1'b1, 4'b1100, 4'b0100);
        applyStimulus("cont3",    1'b1, 4'b1100, 4'b1000);

        applyStimulus("ptr0",     1'b1, 4'b0011, 4'b0001);
        applyStimulus("ptr1",     1'b1, 4'b0011, 4'b0010);
        applyStimulus("ptr2",     1'b1, 4'b0011, 4'b0001);
        applyStimulus("solo3",    1'b1, 4'b1000, 4'b1000);

        applyStimulus("all0",     1'b1, 4'b1111, 4'b0001);
        applyStimulus("all1",     1'b1, 4'b1111, 4'b0010);
        applyStimulus("all2",     1'b1, 4'b1111, 4'b0100);
        applyStimulus("all3",     1'b1, 4'b1111, 4'b1000);
        applyStimulus("all4",     1'b1, 4'b1111, 4'b0001);
        applyStimulus("drop",     1'b1, 4'b0000, 4'b0000);
        applyStimulus("resume",   1'b1, 4'b1111, 4'b0010);

        applyStimulus("single0",  1'b1, 4'b0100, 4'b0100);
        applyStimulus("single1",  1'b1, 4'b0100, 4'b0100);
        applyStimulus("single2",  1'b1, 4'b0100, 4'b0100);

        applyStimulus("withdraw", 1'b1, 4'b1001, 4'b1000);
        applyStimulus("midRst",   1'b0, 4'b0000, 4'b0000);
        applyStimulus("postRst0", 1'b1, 4'b1111, 4'b0001);
        applyStimulus("postRst1", 1'b1, 4'b1111, 4'b0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
